// File: rtl/cdb_multi.sv
// Multi-lane common data bus: per-unit FIFOs, round-robin grant of up to NUM_CDB heads per cycle, registered broadcast.
// Latency is 2 cycles from accept to cdb_valid. fu_ready is per-unit FIFO space, with no same-cycle dequeue credit.

module cdb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         ready
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push  = push && !flush;
  assign do_pop   = pop && !flush;
  assign ready    = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[head];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= wrap_inc(tail);
      if (do_pop)  head <= wrap_inc(head);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is only read when non-empty, so it carries no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[tail] <= push_dat;
  end
endmodule

module cdb_multi #(
  parameter int NUM_FU    = 4,
  parameter int NUM_CDB   = 2,
  parameter int BUF_DEPTH = 2,
  parameter int XLEN      = 32,
  parameter int PRF_LEN   = 6,
  parameter int ROB_LEN   = 5,
  parameter int AUX_W     = 36
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [NUM_FU-1:0]                   fu_valid,
  output logic [NUM_FU-1:0]                   fu_ready,
  input  logic [NUM_FU*XLEN-1:0]              fu_value,
  input  logic [NUM_FU*PRF_LEN-1:0]           fu_prf_idx,
  input  logic [NUM_FU*ROB_LEN-1:0]           fu_rob_idx,
  input  logic [NUM_FU*XLEN-1:0]              fu_PC,
  input  logic [NUM_FU*AUX_W-1:0]             fu_aux,
  output logic [NUM_CDB-1:0]                  cdb_valid,
  output logic [NUM_CDB*XLEN-1:0]             cdb_value,
  output logic [NUM_CDB*PRF_LEN-1:0]          cdb_prf_idx,
  output logic [NUM_CDB*ROB_LEN-1:0]          cdb_rob_idx,
  output logic [NUM_CDB*XLEN-1:0]             cdb_PC,
  output logic [NUM_CDB*AUX_W-1:0]            cdb_aux,
  output logic [NUM_CDB*$clog2(NUM_FU)-1:0]   cdb_src
);
  localparam int SRC_W = $clog2(NUM_FU);

  typedef struct packed {
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic [XLEN-1:0]    pc;
    logic [AUX_W-1:0]   aux;
  } result_t;

  result_t              fu_res   [NUM_FU];
  result_t              head_res [NUM_FU];
  logic [NUM_FU-1:0]    fifo_empty;
  logic [NUM_FU-1:0]    fifo_push;
  logic [NUM_FU-1:0]    fifo_pop;

  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     rr_next;
  logic [SRC_W-1:0]     grant_src [NUM_CDB];
  logic [NUM_CDB-1:0]   grant_vld;

  result_t              lane_res [NUM_CDB];
  logic [SRC_W-1:0]     lane_src [NUM_CDB];

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign fu_res[i] = '{
      value:   fu_value[i*XLEN +: XLEN],
      prf_idx: fu_prf_idx[i*PRF_LEN +: PRF_LEN],
      rob_idx: fu_rob_idx[i*ROB_LEN +: ROB_LEN],
      pc:      fu_PC[i*XLEN +: XLEN],
      aux:     fu_aux[i*AUX_W +: AUX_W]
    };
    assign fifo_push[i] = fu_valid[i] && fu_ready[i];

    cdb_fifo #(
      .W     ($bits(result_t)),
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (flush),
      .push     (fifo_push[i]),
      .push_dat (fu_res[i]),
      .pop      (fifo_pop[i]),
      .head_dat (head_res[i]),
      .empty    (fifo_empty[i]),
      .ready    (fu_ready[i])
    );
  end

  // Scan from rr_ptr; the k-th non-empty unit found goes to lane k.
  always_comb begin
    int n;
    int idx;
    grant_vld = '0;
    fifo_pop  = '0;
    rr_next   = rr_ptr;
    n         = 0;
    idx       = 0;
    for (int j = 0; j < NUM_CDB; j++) grant_src[j] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!fifo_empty[idx] && n < NUM_CDB) begin
        grant_src[n] = SRC_W'(idx);
        grant_vld[n] = 1'b1;
        fifo_pop[idx] = 1'b1;
        rr_next = (idx == NUM_FU - 1) ? '0 : SRC_W'(idx + 1);
        n = n + 1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      for (int j = 0; j < NUM_CDB; j++) begin
        lane_res[j] <= '0;
        lane_src[j] <= '0;
      end
    end else if (flush) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      for (int j = 0; j < NUM_CDB; j++) begin
        lane_res[j] <= '0;
        lane_src[j] <= '0;
      end
    end else begin
      rr_ptr    <= rr_next;
      cdb_valid <= grant_vld;
      for (int j = 0; j < NUM_CDB; j++) begin
        lane_res[j] <= grant_vld[j] ? head_res[grant_src[j]] : '0;
        lane_src[j] <= grant_vld[j] ? grant_src[j] : '0;
      end
    end
  end

  for (genvar j = 0; j < NUM_CDB; j++) begin : g_lane
    assign cdb_value[j*XLEN +: XLEN]         = lane_res[j].value;
    assign cdb_prf_idx[j*PRF_LEN +: PRF_LEN] = lane_res[j].prf_idx;
    assign cdb_rob_idx[j*ROB_LEN +: ROB_LEN] = lane_res[j].rob_idx;
    assign cdb_PC[j*XLEN +: XLEN]            = lane_res[j].pc;
    assign cdb_aux[j*AUX_W +: AUX_W]         = lane_res[j].aux;
    assign cdb_src[j*SRC_W +: SRC_W]         = lane_src[j];
  end
endmodule

// File: tb/tb_cdb_multi.sv
// Scoreboard bench for cdb_multi at default parameters: directed offers push expected broadcasts, a negedge monitor checks them.
module tb_cdb_multi;
  localparam int NFU = 4, NCDB = 2, XL = 32, PL = 6, RL = 5, AW = 36, SW = 2;

  logic                 clock;
  logic                 reset;
  logic                 flush;
  logic [NFU-1:0]       fu_valid;
  logic [NFU-1:0]       fu_ready;
  logic [NFU*XL-1:0]    fu_value;
  logic [NFU*PL-1:0]    fu_prf_idx;
  logic [NFU*RL-1:0]    fu_rob_idx;
  logic [NFU*XL-1:0]    fu_PC;
  logic [NFU*AW-1:0]    fu_aux;
  logic [NCDB-1:0]      cdb_valid;
  logic [NCDB*XL-1:0]   cdb_value;
  logic [NCDB*PL-1:0]   cdb_prf_idx;
  logic [NCDB*RL-1:0]   cdb_rob_idx;
  logic [NCDB*XL-1:0]   cdb_PC;
  logic [NCDB*AW-1:0]   cdb_aux;
  logic [NCDB*SW-1:0]   cdb_src;

  cdb_multi #(
    .NUM_FU(NFU), .NUM_CDB(NCDB), .BUF_DEPTH(2), .XLEN(XL),
    .PRF_LEN(PL), .ROB_LEN(RL), .AUX_W(AW)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_value(fu_value),
    .fu_prf_idx(fu_prf_idx), .fu_rob_idx(fu_rob_idx), .fu_PC(fu_PC), .fu_aux(fu_aux),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_prf_idx(cdb_prf_idx),
    .cdb_rob_idx(cdb_rob_idx), .cdb_PC(cdb_PC), .cdb_aux(cdb_aux), .cdb_src(cdb_src)
  );

  typedef struct {
    int            cy;
    int            lane;
    int            src;
    logic [XL-1:0] val;
    logic [PL-1:0] prf;
    logic [RL-1:0] rob;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   c;
  int   d;
  int   hold_k[7]   = '{0, 1, 2, 3, 3, 4, 4};
  int   hold_rdy[7] = '{1, 1, 1, 0, 1, 0, 1};

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [XL-1:0] pc_of(input logic [XL-1:0] v);
    return v ^ 32'h0000_4004;
  endfunction

  function automatic logic [AW-1:0] aux_of(input logic [XL-1:0] v);
    return {4'h5, ~v};
  endfunction

  function automatic logic [XL-1:0] bv(input int h, input int u, input int k);
    return 32'hB000_0000 + 32'(h * 4096 + u * 256 + k);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    fu_valid = '0; fu_value = '0; fu_prf_idx = '0; fu_rob_idx = '0; fu_PC = '0; fu_aux = '0;
  endtask

  task automatic set_fu(input int u, input logic [XL-1:0] v, input logic [PL-1:0] p, input logic [RL-1:0] r);
    fu_valid[u]          = 1'b1;
    fu_value[u*XL +: XL] = v;
    fu_prf_idx[u*PL +: PL] = p;
    fu_rob_idx[u*RL +: RL] = r;
    fu_PC[u*XL +: XL]    = pc_of(v);
    fu_aux[u*AW +: AW]   = aux_of(v);
  endtask

  task automatic sb_push(input int cy, input int lane, input int src, input logic [XL-1:0] v,
                         input logic [PL-1:0] p, input logic [RL-1:0] r);
    exp_t e;
    e.cy = cy; e.lane = lane; e.src = src; e.val = v; e.prf = p; e.rob = r;
    sb.push_back(e);
  endtask

  task automatic bl_exp(input int cy, input int lane, input int h, input int u, input int k);
    sb_push(cy, lane, u, bv(h, u, k), 6'(u * 8 + k), 5'(u * 4 + k));
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Unit h re-offers a held result while the other three units preload two results each.
  task automatic run_backlog(input int h);
    int b;
    do_flush();
    b = cyc;
    bl_exp(b + 2, 0, h, 0, 0); bl_exp(b + 2, 1, h, 1, 0);
    bl_exp(b + 3, 0, h, 2, 0); bl_exp(b + 3, 1, h, 3, 0);
    bl_exp(b + 4, 0, h, 0, 1); bl_exp(b + 4, 1, h, 1, 1);
    bl_exp(b + 5, 0, h, 2, 1); bl_exp(b + 5, 1, h, 3, 1);
    bl_exp(b + 6, 0, h, h, 2);
    bl_exp(b + 7, 0, h, h, 3);
    bl_exp(b + 8, 0, h, h, 4);
    for (int t = 0; t < 7; t++) begin
      clr();
      for (int u = 0; u < NFU; u++)
        if (u != h && t < 2) set_fu(u, bv(h, u, t), 6'(u * 8 + t), 5'(u * 4 + t));
      set_fu(h, bv(h, h, hold_k[t]), 6'(h * 8 + hold_k[t]), 5'(h * 4 + hold_k[t]));
      chk($sformatf("backlog%0d_ready_t%0d", h, t), 64'(fu_ready[h]), 64'(hold_rdy[t]));
      tick();
    end
    clr();
    repeat (4) tick();
  endtask

  always @(negedge clock) begin
    for (int j = 0; j < NCDB; j++) begin
      tests++;
      if (cdb_valid[j]) begin
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL bcast_unexpected cyc=%0d lane=%0d src=%0d value=%h", cyc, j,
                   cdb_src[j*SW +: SW], cdb_value[j*XL +: XL]);
        end else begin
          me = sb.pop_front();
          if (me.cy != cyc || me.lane != j || int'(cdb_src[j*SW +: SW]) != me.src ||
              cdb_value[j*XL +: XL] !== me.val || cdb_prf_idx[j*PL +: PL] !== me.prf ||
              cdb_rob_idx[j*RL +: RL] !== me.rob || cdb_PC[j*XL +: XL] !== pc_of(me.val) ||
              cdb_aux[j*AW +: AW] !== aux_of(me.val)) begin
            fails++;
            $display("FAIL bcast got cyc=%0d lane=%0d src=%0d val=%h prf=%0d rob=%0d pc=%h aux=%h; expected cyc=%0d lane=%0d src=%0d val=%h prf=%0d rob=%0d",
                     cyc, j, cdb_src[j*SW +: SW], cdb_value[j*XL +: XL], cdb_prf_idx[j*PL +: PL],
                     cdb_rob_idx[j*RL +: RL], cdb_PC[j*XL +: XL], cdb_aux[j*AW +: AW],
                     me.cy, me.lane, me.src, me.val, me.prf, me.rob);
          end
        end
      end else if (cdb_value[j*XL +: XL] !== '0 || cdb_prf_idx[j*PL +: PL] !== '0 ||
                   cdb_rob_idx[j*RL +: RL] !== '0 || cdb_PC[j*XL +: XL] !== '0 ||
                   cdb_aux[j*AW +: AW] !== '0 || cdb_src[j*SW +: SW] !== '0) begin
        fails++;
        $display("FAIL idle_lane_zero cyc=%0d lane=%0d value=%h src=%0d, required all zero",
                 cyc, j, cdb_value[j*XL +: XL], cdb_src[j*SW +: SW]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clr();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_valid", 64'(cdb_valid), 64'h0);
    chk("reset_ready", 64'(fu_ready), 64'hf);
    chk("reset_value", cdb_value, 64'h0);
    reset = 1'b0;
    tick();

    // Single result from unit 2, empty FIFO.
    c = cyc;
    set_fu(2, 32'h1234, 6'd5, 5'd3);
    sb_push(c + 2, 0, 2, 32'h1234, 6'd5, 5'd3);
    tick();
    clr();
    chk("single_ready", 64'(fu_ready), 64'hf);
    repeat (4) tick();

    // All four units at once, then rr_ptr must be back at 0.
    do_flush();
    c = cyc;
    for (int u = 0; u < NFU; u++) set_fu(u, 32'(32'h2000 + u), 6'(u), 5'(u));
    for (int u = 0; u < NFU; u++) sb_push(c + 2 + u / 2, u % 2, u, 32'(32'h2000 + u), 6'(u), 5'(u));
    tick();
    clr();
    tick();
    tick();
    d = cyc;
    set_fu(0, 32'h2100, 6'd10, 5'd10);
    set_fu(3, 32'h2103, 6'd13, 5'd13);
    sb_push(d + 2, 0, 0, 32'h2100, 6'd10, 5'd10);
    sb_push(d + 2, 1, 3, 32'h2103, 6'd13, 5'd13);
    tick();
    clr();
    repeat (4) tick();

    run_backlog(0);
    run_backlog(1);

    // Flush with three buffered entries and a fresh offer on unit 0.
    do_flush();
    c = cyc;
    set_fu(0, 32'h5000, 6'd1, 5'd1);
    sb_push(c + 2, 0, 0, 32'h5000, 6'd1, 5'd1);
    tick();
    clr();
    for (int u = 1; u < NFU; u++) set_fu(u, 32'(32'h5100 + u), 6'(u), 5'(u));
    tick();
    clr();
    flush = 1'b1;
    set_fu(0, 32'h5eee, 6'd2, 5'd2);
    tick();
    flush = 1'b0;
    clr();
    chk("flush_valid", 64'(cdb_valid), 64'h0);
    chk("flush_ready", 64'(fu_ready), 64'hf);
    repeat (5) tick();

    // Asynchronous reset in the middle of a burst.
    c = cyc;
    for (int u = 0; u < NFU; u++) set_fu(u, 32'(32'h6000 + u), 6'(u + 20), 5'(u + 20));
    sb_push(c + 2, 0, 0, 32'h6000, 6'd20, 5'd20);
    sb_push(c + 2, 1, 1, 32'h6001, 6'd21, 5'd21);
    tick();
    clr();
    tick();
    tick();
    chk("prereset_valid", 64'(cdb_valid), 64'h3);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(cdb_valid), 64'h0);
    chk("async_reset_value", cdb_value, 64'h0);
    chk("async_reset_src", 64'(cdb_src), 64'h0);
    chk("async_reset_ready", 64'(fu_ready), 64'hf);
    tick();
    tick();
    reset = 1'b0;
    tick();
    c = cyc;
    set_fu(3, 32'h6abc, 6'd33, 5'd17);
    sb_push(c + 2, 0, 3, 32'h6abc, 6'd33, 5'd17);
    tick();
    clr();
    repeat (5) tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
